id_stage: RTL and testbench

- Instruction-decode stage for the Simple-MIPS pipeline. Decodes the logic/shift/immediate subset of the MIPS ISA, reads the register file, and forwards results from EX and MEM.
- Detects RAW hazards and either stalls or forwards depending on mode.
- Holds the ID/EX pipeline register behind a valid/ready handshake on both sides.
- Sits between the IF/ID register and the EX stage, and drives register-file read ports directly.

---
 rtl/id_stage.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage for the Simple-MIPS logic/shift/immediate subset: decodes, resolves operands
// with EX/MEM forwarding, detects RAW hazards and holds the valid/ready ID/EX register.
module id_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,

    output logic              rf_re1_o,
    output logic              rf_re2_o,
    output logic [REG_AW-1:0] rf_raddr1_o,
    output logic [REG_AW-1:0] rf_raddr2_o,
    input  logic [DATA_W-1:0] rf_rdata1_i,
    input  logic [DATA_W-1:0] rf_rdata2_i,

    input  logic              ex_we_i,
    input  logic [REG_AW-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_pc_o,
    output logic [7:0]        out_aluop_o,
    output logic [2:0]        out_alusel_o,
    output logic [DATA_W-1:0] out_reg1_o,
    output logic [DATA_W-1:0] out_reg2_o,
    output logic              out_we_o,
    output logic [REG_AW-1:0] out_waddr_o,
    output logic              out_illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [7:0] ALU_OR  = 8'h25;
    localparam logic [7:0] ALU_AND = 8'h24;
    localparam logic [7:0] ALU_XOR = 8'h26;
    localparam logic [7:0] ALU_NOR = 8'h27;
    localparam logic [7:0] ALU_SLL = 8'h7C;
    localparam logic [7:0] ALU_SRL = 8'h02;
    localparam logic [7:0] ALU_SRA = 8'h03;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    typedef struct packed {
        logic [31:0]       pc;
        logic [7:0]        aluop;
        logic [2:0]        alusel;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic              illegal;
    } payload_t;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;

    assign opcode = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign rd     = inst_i[15:11];
    assign shamt  = inst_i[10:6];
    assign funct  = inst_i[5:0];
    assign imm16  = inst_i[15:0];

    // Decoded control
    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic [1:0]        dec_re;
    logic              dec_we;
    logic [REG_AW-1:0] dec_waddr;
    logic              dec_illegal;
    logic [DATA_W-1:0] dec_imm1;
    logic [DATA_W-1:0] dec_imm2;

    always_comb begin
        dec_aluop   = '0;
        dec_alusel  = '0;
        dec_re      = '0;
        dec_we      = 1'b0;
        dec_waddr   = '0;
        dec_illegal = 1'b0;
        dec_imm1    = '0;
        dec_imm2    = '0;
        case (opcode)
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_alusel = SEL_LOGIC;
                dec_re     = 2'b01;
                dec_we     = 1'b1;
                dec_waddr  = REG_AW'(rt);
                dec_imm2   = DATA_W'(imm16);
                case (opcode)
                    OP_ANDI: dec_aluop = ALU_AND;
                    OP_XORI: dec_aluop = ALU_XOR;
                    default: dec_aluop = ALU_OR;
                endcase
            end
            OP_LUI: begin
                // Computed as rs | {imm,0}; the assembler guarantees rs == $0
                dec_aluop  = ALU_OR;
                dec_alusel = SEL_LOGIC;
                dec_re     = 2'b01;
                dec_we     = 1'b1;
                dec_waddr  = REG_AW'(rt);
                dec_imm2   = DATA_W'({imm16, 16'h0000});
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_OR, FN_AND, FN_XOR, FN_NOR: begin
                        dec_alusel = SEL_LOGIC;
                        dec_re     = 2'b11;
                        dec_we     = 1'b1;
                        dec_waddr  = REG_AW'(rd);
                        case (funct)
                            FN_AND:  dec_aluop = ALU_AND;
                            FN_XOR:  dec_aluop = ALU_XOR;
                            FN_NOR:  dec_aluop = ALU_NOR;
                            default: dec_aluop = ALU_OR;
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec_alusel = SEL_SHIFT;
                        dec_re     = 2'b10;
                        dec_we     = 1'b1;
                        dec_waddr  = REG_AW'(rd);
                        dec_imm1   = DATA_W'(shamt);
                        case (funct)
                            FN_SRL:  dec_aluop = ALU_SRL;
                            FN_SRA:  dec_aluop = ALU_SRA;
                            default: dec_aluop = ALU_SLL;
                        endcase
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Writes to $0 are dropped, which turns the all-zero word into a NOP
        if (dec_waddr == '0) begin
            dec_we = 1'b0;
        end
    end

    // Per read-port operand resolution and hazard detection
    logic [REG_AW-1:0] port_addr  [2];
    logic [DATA_W-1:0] port_rdata [2];
    logic [DATA_W-1:0] port_imm   [2];
    logic [DATA_W-1:0] port_opnd  [2];
    logic [1:0]        port_re;
    logic [1:0]        port_hazard;

    assign port_addr[0]  = REG_AW'(rs);
    assign port_addr[1]  = REG_AW'(rt);
    assign port_rdata[0] = rf_rdata1_i;
    assign port_rdata[1] = rf_rdata2_i;
    assign port_imm[0]   = dec_imm1;
    assign port_imm[1]   = dec_imm2;
    assign port_re       = dec_re & {2{in_valid_i}};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              addr_nz;
            logic              match_ex;
            logic              match_mem;
            logic [DATA_W-1:0] opnd;

            assign addr_nz   = (port_addr[gi] != '0);
            assign match_ex  = ex_we_i && (ex_waddr_i == port_addr[gi]);
            assign match_mem = mem_we_i && (mem_waddr_i == port_addr[gi]);

            // EX is younger than MEM, so its value wins when both match
            always_comb begin
                if (!port_re[gi]) begin
                    opnd = port_imm[gi];
                end else if (!addr_nz) begin
                    opnd = '0;
                end else if ((FWD_EN != 0) && match_ex) begin
                    opnd = ex_wdata_i;
                end else if ((FWD_EN != 0) && match_mem) begin
                    opnd = mem_wdata_i;
                end else begin
                    opnd = port_rdata[gi];
                end
            end
            assign port_opnd[gi] = opnd;

            if (FWD_EN != 0) begin : g_fwd
                assign port_hazard[gi] = port_re[gi] & addr_nz & match_ex & ex_is_load_i;
            end else begin : g_nofwd
                assign port_hazard[gi] = port_re[gi] & addr_nz & (match_ex | match_mem);
            end
        end
    endgenerate

    assign rf_re1_o    = port_re[0];
    assign rf_re2_o    = port_re[1];
    assign rf_raddr1_o = port_addr[0];
    assign rf_raddr2_o = port_addr[1];

    // Handshake
    logic hazard;
    logic slot_free;
    logic transfer;

    assign hazard     = |port_hazard;
    assign slot_free  = !out_valid_o || out_ready_i;
    assign in_ready_o = rst && (flush_i || (slot_free && !hazard));
    assign transfer   = in_valid_i && in_ready_o;

    // ID/EX register
    payload_t          payload_dec;
    payload_t          payload_reg;
    payload_t          payload_next;
    logic              valid_reg;
    logic              valid_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_next;

    always_comb begin
        payload_dec.pc      = pc_i;
        payload_dec.aluop   = dec_aluop;
        payload_dec.alusel  = dec_alusel;
        payload_dec.reg1    = port_opnd[0];
        payload_dec.reg2    = port_opnd[1];
        payload_dec.we      = dec_we;
        payload_dec.waddr   = dec_waddr;
        payload_dec.illegal = dec_illegal;
    end

    always_comb begin
        valid_next   = valid_reg;
        payload_next = payload_reg;
        if (!rst || flush_i) begin
            valid_next   = 1'b0;
            payload_next = '0;
        end else if (slot_free) begin
            // A free slot with no transfer (idle or hazard) becomes a bubble
            valid_next   = transfer;
            payload_next = transfer ? payload_dec : '0;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!rst) begin
            stall_cnt_next = '0;
        end else if (!flush_i && in_valid_i && hazard && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        valid_reg     <= valid_next;
        payload_reg   <= payload_next;
        stall_cnt_reg <= stall_cnt_next;
    end

    assign out_valid_o   = valid_reg;
    assign out_pc_o      = payload_reg.pc;
    assign out_aluop_o   = payload_reg.aluop;
    assign out_alusel_o  = payload_reg.alusel;
    assign out_reg1_o    = payload_reg.reg1;
    assign out_reg2_o    = payload_reg.reg2;
    assign out_we_o      = payload_reg.we;
    assign out_waddr_o   = payload_reg.waddr;
    assign out_illegal_o = payload_reg.illegal;
    assign stall_cnt_o   = stall_cnt_reg;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: one forwarding and one non-forwarding instance share stimulus and are
// compared every cycle against an instruction-level reference model.
module tb_id_stage;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW_N = 4;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        re1;
        logic        re2;
        logic        we;
        logic [4:0]  waddr;
        logic        illegal;
        logic [31:0] imm1;
        logic [31:0] imm2;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic        we;
        logic [4:0]  waddr;
        logic        illegal;
        int          cnt;
    } pipe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush_i, in_valid_i, out_ready_i;
    logic [31:0]   pc_i, inst_i;
    logic [DW-1:0] rf_rdata1_i, rf_rdata2_i;
    logic          ex_we_i, ex_is_load_i, mem_we_i;
    logic [AW-1:0] ex_waddr_i, mem_waddr_i;
    logic [DW-1:0] ex_wdata_i, mem_wdata_i;

    logic in_ready_f, rf_re1_f, rf_re2_f, out_valid_f, out_we_f, out_illegal_f;
    logic [AW-1:0] rf_raddr1_f, rf_raddr2_f, out_waddr_f;
    logic [31:0] out_pc_f;
    logic [7:0] out_aluop_f;
    logic [2:0] out_alusel_f;
    logic [DW-1:0] out_reg1_f, out_reg2_f;
    logic [15:0] stall_cnt_f;

    logic in_ready_n, rf_re1_n, rf_re2_n, out_valid_n, out_we_n, out_illegal_n;
    logic [AW-1:0] rf_raddr1_n, rf_raddr2_n, out_waddr_n;
    logic [31:0] out_pc_n;
    logic [7:0] out_aluop_n;
    logic [2:0] out_alusel_n;
    logic [DW-1:0] out_reg1_n, out_reg2_n;
    logic [CW_N-1:0] stall_cnt_n;

    id_stage #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(1), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_f), .pc_i(pc_i), .inst_i(inst_i),
        .rf_re1_o(rf_re1_f), .rf_re2_o(rf_re2_f),
        .rf_raddr1_o(rf_raddr1_f), .rf_raddr2_o(rf_raddr2_f),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(out_valid_f), .out_ready_i(out_ready_i), .out_pc_o(out_pc_f),
        .out_aluop_o(out_aluop_f), .out_alusel_o(out_alusel_f),
        .out_reg1_o(out_reg1_f), .out_reg2_o(out_reg2_f),
        .out_we_o(out_we_f), .out_waddr_o(out_waddr_f), .out_illegal_o(out_illegal_f),
        .stall_cnt_o(stall_cnt_f)
    );

    id_stage #(.DATA_W(DW), .REG_AW(AW), .FWD_EN(0), .CNT_W(CW_N)) dut_n (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_n), .pc_i(pc_i), .inst_i(inst_i),
        .rf_re1_o(rf_re1_n), .rf_re2_o(rf_re2_n),
        .rf_raddr1_o(rf_raddr1_n), .rf_raddr2_o(rf_raddr2_n),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(out_valid_n), .out_ready_i(out_ready_i), .out_pc_o(out_pc_n),
        .out_aluop_o(out_aluop_n), .out_alusel_o(out_alusel_n),
        .out_reg1_o(out_reg1_n), .out_reg2_o(out_reg2_n),
        .out_we_o(out_we_n), .out_waddr_o(out_waddr_n), .out_illegal_o(out_illegal_n),
        .stall_cnt_o(stall_cnt_n)
    );

    int checks = 0;
    int failures = 0;
    pipe_t m [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // What the instruction means, from the ISA subset table
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d = '0;
        case (inst[31:26])
            6'h0D, 6'h0C, 6'h0E, 6'h0F: begin
                d.aluop  = (inst[31:26] == 6'h0C) ? 8'h24 : (inst[31:26] == 6'h0E) ? 8'h26 : 8'h25;
                d.alusel = 3'b001;
                d.re1    = 1'b1;
                d.waddr  = inst[20:16];
                d.imm2   = (inst[31:26] == 6'h0F) ? {inst[15:0], 16'h0} : {16'h0, inst[15:0]};
            end
            6'h00: begin
                case (inst[5:0])
                    6'h25: d.aluop = 8'h25;
                    6'h24: d.aluop = 8'h24;
                    6'h26: d.aluop = 8'h26;
                    6'h27: d.aluop = 8'h27;
                    6'h00: d.aluop = 8'h7C;
                    6'h02: d.aluop = 8'h02;
                    6'h03: d.aluop = 8'h03;
                    default: d.illegal = 1'b1;
                endcase
                if (!d.illegal) begin
                    d.waddr = inst[15:11];
                    d.re2   = 1'b1;
                    if (inst[5:0] inside {6'h00, 6'h02, 6'h03}) begin
                        d.alusel = 3'b010;
                        d.imm1   = {27'h0, inst[10:6]};
                    end else begin
                        d.alusel = 3'b001;
                        d.re1    = 1'b1;
                    end
                end
            end
            default: d.illegal = 1'b1;
        endcase
        d.we = !d.illegal && (d.waddr != 5'd0);
        return d;
    endfunction

    // Advance model k by one cycle using the current inputs; returns expected comb outputs
    task automatic eval_model(input int k, input bit fwd, input int cmax,
                              output logic rdy, output logic re1, output logic re2);
        dec_t d;
        logic [4:0]  a [2];
        logic        re [2];
        logic [31:0] imm [2];
        logic [31:0] rd [2];
        logic [31:0] opnd [2];
        logic        hz, free, mex, mmem;
        pipe_t       nx;
        d = decode(inst_i);
        a[0] = inst_i[25:21];
        a[1] = inst_i[20:16];
        re[0] = d.re1 && in_valid_i;
        re[1] = d.re2 && in_valid_i;
        imm[0] = d.imm1;
        imm[1] = d.imm2;
        rd[0] = rf_rdata1_i;
        rd[1] = rf_rdata2_i;
        hz = 1'b0;
        for (int p = 0; p < 2; p++) begin
            mex  = ex_we_i && (ex_waddr_i == a[p]);
            mmem = mem_we_i && (mem_waddr_i == a[p]);
            if (!re[p]) opnd[p] = imm[p];
            else if (a[p] == 5'd0) opnd[p] = '0;
            else if (fwd && mex) opnd[p] = ex_wdata_i;
            else if (fwd && mmem) opnd[p] = mem_wdata_i;
            else opnd[p] = rd[p];
            if (re[p] && a[p] != 5'd0)
                hz = hz | (fwd ? (mex && ex_is_load_i) : (mex || mmem));
        end
        free = !m[k].valid || out_ready_i;
        rdy  = rst && (flush_i || (free && !hz));
        re1  = re[0];
        re2  = re[1];
        nx = m[k];
        if (!rst || flush_i || (free && !(in_valid_i && rdy))) begin
            nx = '0;
            nx.cnt = m[k].cnt;
        end else if (free) begin
            nx.valid   = 1'b1;
            nx.pc      = pc_i;
            nx.aluop   = d.aluop;
            nx.alusel  = d.alusel;
            nx.reg1    = opnd[0];
            nx.reg2    = opnd[1];
            nx.we      = d.we;
            nx.waddr   = d.waddr;
            nx.illegal = d.illegal;
        end
        if (!rst) nx.cnt = 0;
        else if (!flush_i && in_valid_i && hz && m[k].cnt < cmax) nx.cnt = m[k].cnt + 1;
        m[k] = nx;
    endtask

    task automatic cmp_pipe(input string p, input pipe_t o, input pipe_t e);
        chk({p, ".out_valid"}, o.valid, e.valid);
        chk({p, ".out_pc"}, o.pc, e.pc);
        chk({p, ".out_aluop"}, o.aluop, e.aluop);
        chk({p, ".out_alusel"}, o.alusel, e.alusel);
        chk({p, ".out_reg1"}, o.reg1, e.reg1);
        chk({p, ".out_reg2"}, o.reg2, e.reg2);
        chk({p, ".out_we"}, o.we, e.we);
        chk({p, ".out_waddr"}, o.waddr, e.waddr);
        chk({p, ".out_illegal"}, o.illegal, e.illegal);
        chk({p, ".stall_cnt"}, o.cnt, e.cnt);
    endtask

    // One cycle: comb checks at negedge, registered checks just after posedge
    task automatic step();
        logic  rdy_f, r1_f, r2_f, rdy_n, r1_n, r2_n;
        pipe_t o;
        @(negedge clk);
        eval_model(0, 1'b1, 65535, rdy_f, r1_f, r2_f);
        eval_model(1, 1'b0, (1 << CW_N) - 1, rdy_n, r1_n, r2_n);
        chk("F.in_ready", in_ready_f, rdy_f);
        chk("F.rf_re1", rf_re1_f, r1_f);
        chk("F.rf_re2", rf_re2_f, r2_f);
        chk("F.rf_raddr1", rf_raddr1_f, inst_i[25:21]);
        chk("F.rf_raddr2", rf_raddr2_f, inst_i[20:16]);
        chk("N.in_ready", in_ready_n, rdy_n);
        chk("N.rf_re1", rf_re1_n, r1_n);
        chk("N.rf_re2", rf_re2_n, r2_n);
        @(posedge clk);
        #1;
        o = '0;
        o.valid = out_valid_f; o.pc = out_pc_f; o.aluop = out_aluop_f; o.alusel = out_alusel_f;
        o.reg1 = out_reg1_f; o.reg2 = out_reg2_f; o.we = out_we_f; o.waddr = out_waddr_f;
        o.illegal = out_illegal_f; o.cnt = 32'(stall_cnt_f);
        cmp_pipe("F", o, m[0]);
        o.valid = out_valid_n; o.pc = out_pc_n; o.aluop = out_aluop_n; o.alusel = out_alusel_n;
        o.reg1 = out_reg1_n; o.reg2 = out_reg2_n; o.we = out_we_n; o.waddr = out_waddr_n;
        o.illegal = out_illegal_n; o.cnt = 32'(stall_cnt_n);
        cmp_pipe("N", o, m[1]);
        $display("cycle t=%0t inst=%08h v=%0b rdyF=%0b outF=%0b outN=%0b cntF=%0d cntN=%0d",
                 $time, inst_i, in_valid_i, rdy_f, out_valid_f, out_valid_n,
                 stall_cnt_f, stall_cnt_n);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  fn;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 8))
            0: return {6'h0D, rs, rt, imm};
            1: return {6'h0C, rs, rt, imm};
            2: return {6'h0E, rs, rt, imm};
            3: return {6'h0F, 5'd0, rt, imm};
            4, 5: begin
                fn = 6'(6'h24 + $urandom_range(0, 3));
                return {6'h00, rs, rt, rd, 5'd0, fn};
            end
            6: begin
                fn = 6'($urandom_range(0, 3));
                return {6'h00, 5'd0, rt, rd, sh, fn};
            end
            7: return {6'h00, rs, rt, rd, sh, 6'($urandom)};
            default: return $urandom();
        endcase
    endfunction

    initial begin
        m[0] = '0;
        m[1] = '0;
        rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
        pc_i = 32'h100; inst_i = 32'h3423_1234;
        rf_rdata1_i = 32'h0000_1100; rf_rdata2_i = 32'h0;
        ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
        mem_we_i = 1'b0; mem_waddr_i = '0; mem_wdata_i = '0;

        // Reset held two cycles with valid input
        step();
        step();
        chk("reset.out_valid", out_valid_f, 1'b0);
        chk("reset.stall_cnt", stall_cnt_f, 16'd0);

        // ORI $3,$1,0x1234
        rst = 1'b1;
        step();
        chk("ori.aluop", out_aluop_f, 8'h25);
        chk("ori.reg1", out_reg1_f, 32'h1100);
        chk("ori.reg2", out_reg2_f, 32'h1234);
        chk("ori.waddr", out_waddr_f, 5'd3);

        // OR $4,$1,$2 with EX writing $1 and MEM writing $2
        pc_i = 32'h104;
        inst_i = {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h25};
        ex_we_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'hAAAA;
        mem_we_i = 1'b1; mem_waddr_i = 5'd2; mem_wdata_i = 32'h5555;
        step();
        chk("fwd.reg1", out_reg1_f, 32'hAAAA);
        chk("fwd.reg2", out_reg2_f, 32'h5555);

        // Load-use: ORI $3,$1,1 behind a load to $1
        pc_i = 32'h108;
        inst_i = {6'h0D, 5'd1, 5'd3, 16'd1};
        ex_is_load_i = 1'b1; mem_we_i = 1'b0;
        rf_rdata1_i = 32'h77;
        step();
        chk("lu.bubble", out_valid_f, 1'b0);
        chk("lu.stall_cnt", stall_cnt_f, 16'd1);
        ex_we_i = 1'b0; ex_is_load_i = 1'b0;
        step();
        chk("lu.accept", out_valid_f, 1'b1);

        // Backpressure for three cycles
        out_ready_i = 1'b0;
        pc_i = 32'h10C;
        inst_i = {6'h0E, 5'd2, 5'd5, 16'hBEEF};
        for (int i = 0; i < 3; i++) step();
        chk("bp.hold_pc", out_pc_f, 32'h108);
        chk("bp.stall_cnt", stall_cnt_f, 16'd1);

        // Illegal word, then the all-zero NOP
        out_ready_i = 1'b1;
        inst_i = 32'hFC00_0000;
        step();
        chk("ill.illegal", out_illegal_f, 1'b1);
        chk("ill.we", out_we_f, 1'b0);
        inst_i = 32'h0;
        step();
        chk("nop.aluop", out_aluop_f, 8'h7C);
        chk("nop.we", out_we_f, 1'b0);

        // Flush over a stalled valid output
        out_ready_i = 1'b0; flush_i = 1'b1;
        inst_i = {6'h0D, 5'd1, 5'd3, 16'd9};
        step();
        chk("flush.out_valid", out_valid_f, 1'b0);
        flush_i = 1'b0;

        // Randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) != 0);
            flush_i      = ($urandom_range(0, 15) == 0);
            in_valid_i   = ($urandom_range(0, 3) != 0);
            out_ready_i  = ($urandom_range(0, 3) != 0);
            pc_i         = $urandom();
            inst_i       = rand_inst();
            rf_rdata1_i  = $urandom();
            rf_rdata2_i  = $urandom();
            ex_we_i      = 1'($urandom_range(0, 1));
            ex_waddr_i   = 5'($urandom_range(0, 3));
            ex_wdata_i   = $urandom();
            ex_is_load_i = 1'($urandom_range(0, 1));
            mem_we_i     = 1'($urandom_range(0, 1));
            mem_waddr_i  = 5'($urandom_range(0, 3));
            mem_wdata_i  = $urandom();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
